avalon_local_mem_responder: RTL and testbench
=============================================

// Module: avalon_local_mem_responder
// PURPOSE
// - Avalon-MM responder (memory side) for one local-memory bank driven by the AFU's avalon_mem_if.to_fiu port.
// - Backs the bank with an on-chip array and returns burst reads after a fixed latency.
// - Injects optional pseudo-random waitrequest stalls so AFU handshake paths are exercised in simulation and on-chip bring-up.
// - One instance per bank.
// PARAMETERS
// DATA_W          512  data bus width, bits; multiple of 8
// ADDR_W          27   word (beat) address width
// BURST_W         7    burstcount width; max burst = 2**(BURST_W-1)
// MEM_LOG2        10   log2 of array depth in beats; address aliases modulo 2**MEM_LOG2
// READ_LATENCY    4    cycles from internal read issue to readdatavalid; >=1
// STALL_EN        0    1 = LFSR-driven waitrequest stalls enabled
// STALL_SEED      16'hACE1  nonzero 16-bit LFSR seed
// PORTS
// clk              in   1          clock
// reset_n          in   1          asynchronous active-low reset
// avs_address      in   ADDR_W     beat address, sampled on command accept
// avs_read         in   1          read request
// avs_write        in   1          write request / write beat
// avs_burstcount   in   BURST_W    beats in burst, sampled on command accept
// avs_writedata    in   DATA_W     write beat data
// avs_byteenable   in   DATA_W/8   per-byte write enable
// avs_waitrequest  out  1          1 = request not accepted this cycle
// avs_readdata     out  DATA_W     read beat data
// avs_readdatavalid out 1          read beat valid, one cycle per beat
// err_sticky       out  1          protocol error seen since reset
// rd_beats         out  32         read beats returned, wraps
// wr_beats         out  32         write beats committed, wraps
// BEHAVIOUR
// - Reset (async assert): waitrequest=1, readdatavalid=0, readdata=0, err_sticky=0, counters=0, state=IDLE.
//   Read pipeline is flushed; LFSR is loaded with STALL_SEED; array contents are not reset.
//   waitrequest may drop no earlier than the first clk edge after reset_n rises.
// - Accept: a beat/command is taken when (read|write) & !waitrequest.
//   With STALL_EN=1, waitrequest is also forced high when LFSR[0]=1, in IDLE/WRITE only. LFSR advances every cycle.
// - FSM IDLE:
//   - write accepted: commits beat 0 at address; burstcount>1 -> WRITE, beats_left=burstcount-1, ptr=addr+1.
//   - read accepted: ptr=addr, beats_left=burstcount -> READ.
//   - read&write together, or burstcount==0: err_sticky=1; the command is accepted and dropped, state stays IDLE.
// - FSM WRITE:
//   - Each accepted write commits writedata, byte-merged, at ptr; ptr+1, beats_left-1.
//   - address/burstcount are ignored on these beats.
//   - Exits to IDLE on the cycle the last beat is committed.
//   - read asserted in WRITE: err_sticky=1, the read is ignored, waitrequest stays low.
// - FSM READ:
//   - waitrequest=1 throughout.
//   - One array read issued per cycle at ptr; ptr+1, beats_left-1.
//   - On the issue of the last beat, goes to IDLE. A new command is accepted the next cycle while earlier beats are still in the pipeline.
// - Read timing: the beat issued in cycle t appears with readdatavalid=1 in cycle t+READ_LATENCY.
//   Beats of one burst are back-to-back with no gaps. readdata holds its last value when not valid.
// - Ordering: the array is read at issue. A write committed after a read issue does not affect that read's data. Same-cycle read/write to one index cannot occur.
// - Address: array index = address[MEM_LOG2-1:0]; ptr increments wrap modulo 2**MEM_LOG2; upper address bits ignored.
// - Counters: +1 per returned beat / committed beat; wrap at 2**32.
// - Reset mid-burst: burst aborted, in-flight beats discarded, no readdatavalid after reset_n rises until a new read is accepted.
// TESTING
// - Write burst 4 @0x10 data D0..D3, be all 1s; read burst 4 @0x10 -> 4 consecutive readdatavalid at accept+1+READ_LATENCY.., data D0..D3; rd_beats=4, wr_beats=4.
// - Write 1 beat @0x20 with be=0x...0F over prior all-FF; read @0x20 -> low 4 bytes new, rest 0xFF.
// - Read burst 2 @0x40 then write @0x40 in the cycle after the READ->IDLE exit -> read returns old data; a later read returns new data.
// - read&write both high in IDLE -> err_sticky=1, no array change, counters unchanged; burstcount=0 -> err_sticky=1.
// - Address 2**MEM_LOG2-1 with burst 3 -> beats at indices max, 0, 1 (wrap); STALL_EN=1 run of 1000 random bursts matches scoreboard.
// - reset_n low during read burst 8 after beat 3 issued -> readdatavalid=0 immediately, waitrequest=1, no stray beats after release.

Source files
------------

// File: rtl/avalon_local_mem_responder_if.sv
// Avalon-MM bus bundle between an AFU-side master and a local-memory responder.
interface avalon_local_mem_responder_if #(
    parameter int unsigned DATA_W  = 512,
    parameter int unsigned ADDR_W  = 27,
    parameter int unsigned BURST_W = 7
);
    logic [ADDR_W-1:0]   avs_address;
    logic                avs_read;
    logic                avs_write;
    logic [BURST_W-1:0]  avs_burstcount;
    logic [DATA_W-1:0]   avs_writedata;
    logic [DATA_W/8-1:0] avs_byteenable;
    logic                avs_waitrequest;
    logic [DATA_W-1:0]   avs_readdata;
    logic                avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_burstcount, avs_writedata, avs_byteenable,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_burstcount, avs_writedata, avs_byteenable,
        output avs_waitrequest, avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/avalon_local_mem_responder.sv
// Avalon-MM memory-side responder for one local-memory bank: on-chip array, burst reads
// returned after a fixed latency, optional LFSR-driven waitrequest stalls.
module avalon_local_mem_responder #(
    parameter int unsigned DATA_W       = 512,
    parameter int unsigned ADDR_W       = 27,
    parameter int unsigned BURST_W      = 7,
    parameter int unsigned MEM_LOG2     = 10,
    parameter int unsigned READ_LATENCY = 4,
    parameter int unsigned STALL_EN     = 0,
    parameter logic [15:0] STALL_SEED   = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    avalon_local_mem_responder_if.slave  avs,
    output logic                         err_sticky,
    output logic [31:0]                  rd_beats,
    output logic [31:0]                  wr_beats
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** MEM_LOG2;

    typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

    state_e               state_q, state_d;
    logic                 ready_q;
    logic [15:0]          lfsr_q;
    logic [MEM_LOG2-1:0]  ptr_q;
    logic [BURST_W-1:0]   beats_left_q;
    logic [DATA_W-1:0]    mem [DEPTH];
    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_W-1:0]    data_q [READ_LATENCY];

    logic                 stall;
    logic                 waitrequest;
    logic                 wr_commit;
    logic                 rd_start;
    logic                 rd_issue;
    logic                 err_set;
    logic [MEM_LOG2-1:0]  wr_idx;
    logic                 unused_addr;

    // Upper address bits alias onto the array and are deliberately ignored.
    assign unused_addr = ^avs.avs_address[ADDR_W-1:MEM_LOG2];

    assign stall                 = (STALL_EN != 0) && lfsr_q[0];
    assign avs.avs_waitrequest   = waitrequest;
    assign avs.avs_readdatavalid = vld_q[READ_LATENCY-1];
    assign avs.avs_readdata      = data_q[READ_LATENCY-1];

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rd_start) begin
                    state_d = StRead;
                end else if (wr_commit && (avs.avs_burstcount > BURST_W'(1))) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (wr_commit && (beats_left_q == BURST_W'(1))) begin
                    state_d = StIdle;
                end
            end
            StRead: begin
                if (beats_left_q == BURST_W'(1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake and datapath strobes decoded from the current state.
    always_comb begin
        waitrequest = 1'b1;
        wr_commit   = 1'b0;
        rd_start    = 1'b0;
        rd_issue    = 1'b0;
        err_set     = 1'b0;
        wr_idx      = ptr_q;
        unique case (state_q)
            StIdle: begin
                waitrequest = !ready_q || stall;
                if (!waitrequest && (avs.avs_read || avs.avs_write)) begin
                    // Malformed commands are accepted and dropped so the master never hangs.
                    if ((avs.avs_read && avs.avs_write) || (avs.avs_burstcount == '0)) begin
                        err_set = 1'b1;
                    end else if (avs.avs_write) begin
                        wr_commit = 1'b1;
                        wr_idx    = avs.avs_address[MEM_LOG2-1:0];
                    end else begin
                        rd_start = 1'b1;
                    end
                end
            end
            StWrite: begin
                waitrequest = stall;
                if (avs.avs_read) begin
                    err_set = 1'b1;
                end
                if (avs.avs_write && !waitrequest) begin
                    wr_commit = 1'b1;
                end
            end
            StRead: begin
                rd_issue = 1'b1;
            end
            default: ;
        endcase
    end

    // Burst pointer / beat counter, ready flag and stall LFSR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q      <= 1'b0;
            lfsr_q       <= STALL_SEED;
            ptr_q        <= '0;
            beats_left_q <= '0;
        end else begin
            ready_q <= 1'b1;
            lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            if (rd_start) begin
                ptr_q        <= avs.avs_address[MEM_LOG2-1:0];
                beats_left_q <= avs.avs_burstcount;
            end else if (wr_commit && (state_q == StIdle)) begin
                ptr_q        <= avs.avs_address[MEM_LOG2-1:0] + MEM_LOG2'(1);
                beats_left_q <= avs.avs_burstcount - BURST_W'(1);
            end else if (wr_commit || rd_issue) begin
                ptr_q        <= ptr_q + MEM_LOG2'(1);
                beats_left_q <= beats_left_q - BURST_W'(1);
            end
        end
    end

    // Array write with byte merge; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int b = 0; b < BE_W; b++) begin
                if (avs.avs_byteenable[b]) begin
                    mem[wr_idx][b*8 +: 8] <= avs.avs_writedata[b*8 +: 8];
                end
            end
        end
    end

    // Read pipeline: array sampled at issue, data stages only load on valid so readdata holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_issue;
            if (rd_issue) begin
                data_q[0] <= mem[ptr_q];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    // Sticky protocol error flag and wrapping beat counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_sticky <= 1'b0;
            rd_beats   <= '0;
            wr_beats   <= '0;
        end else begin
            if (err_set) begin
                err_sticky <= 1'b1;
            end
            if (vld_q[READ_LATENCY-1]) begin
                rd_beats <= rd_beats + 32'd1;
            end
            if (wr_commit) begin
                wr_beats <= wr_beats + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_avalon_local_mem_responder.sv
// Directed bench for avalon_local_mem_responder with stalls enabled, plus a random burst
// run checked against a reference array.
module tb_avalon_local_mem_responder;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 27;
    localparam int unsigned BW = 7;
    localparam int unsigned ML = 8;
    localparam int unsigned RL = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic err_sticky;
    logic [31:0] rd_beats, wr_beats;

    always #5 clk = ~clk;

    avalon_local_mem_responder_if #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW)) bus ();

    avalon_local_mem_responder #(
        .DATA_W(DW), .ADDR_W(AW), .BURST_W(BW), .MEM_LOG2(ML),
        .READ_LATENCY(RL), .STALL_EN(1), .STALL_SEED(16'hACE1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .avs       (bus.slave),
        .err_sticky(err_sticky),
        .rd_beats  (rd_beats),
        .wr_beats  (wr_beats)
    );

    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    int unsigned n_stall = 0;
    int unsigned exp_rd = 0;
    int unsigned exp_wr = 0;

    logic [DW-1:0] model [2**ML];
    logic [DW-1:0] wdat [64];
    logic [7:0]    wbe [64];
    logic [DW-1:0] exp_beats [64];
    logic [DW-1:0] rq_data [$];
    int unsigned   rq_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Capture returned beats with the cycle they appeared in.
    always @(negedge clk) begin
        if (reset_n && bus.avs_readdatavalid) begin
            rq_data.push_back(bus.avs_readdata);
            rq_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] fillval(input int unsigned i);
        return {16'hF1F1, 16'(i), 16'h0F0F, 16'(i)};
    endfunction

    // Waits for the handshake; returns the cycle in which the beat was accepted.
    task automatic wait_accept(input bit count_stall, output int unsigned acc);
        bit done = 1'b0;
        acc = cyc;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!bus.avs_waitrequest) begin
                acc  = cyc;
                done = 1'b1;
            end else if (count_stall) begin
                n_stall++;
            end
            @(posedge clk);
            #1;
            if (done) break;
        end
        if (!done) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input int n);
        int unsigned acc;
        logic [ML-1:0] idx;
        idx = addr[ML-1:0];
        for (int i = 0; i < n; i++) begin
            bus.avs_write      = 1'b1;
            bus.avs_address    = addr;
            bus.avs_burstcount = BW'(n);
            bus.avs_writedata  = wdat[i];
            bus.avs_byteenable = wbe[i];
            wait_accept(i > 0, acc);
            for (int b = 0; b < 8; b++) begin
                if (wbe[i][b]) model[idx][b*8 +: 8] = wdat[i][b*8 +: 8];
            end
            idx = idx + 1'b1;
            exp_wr++;
        end
        bus.avs_write = 1'b0;
    endtask

    task automatic issue_read(input logic [AW-1:0] addr, input int n, output int unsigned acc);
        bus.avs_read       = 1'b1;
        bus.avs_address    = addr;
        bus.avs_burstcount = BW'(n);
        wait_accept(1'b0, acc);
        bus.avs_read = 1'b0;
    endtask

    task automatic collect(input int n, input int unsigned acc, input string tag);
        logic [DW-1:0] d;
        int unsigned c;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 300 && rq_data.size() == 0; k++) begin
                @(posedge clk);
                #1;
            end
            if (rq_data.size() == 0) begin
                check({tag, "_timeout"}, 64'd0, 64'd1);
                return;
            end
            d = rq_data.pop_front();
            c = rq_cyc.pop_front();
            check({tag, "_data"}, d, exp_beats[i]);
            check({tag, "_lat"}, 64'(c), 64'(acc + 1 + RL + i));
            exp_rd++;
        end
    endtask

    initial begin
        int unsigned acc;
        int n;
        logic [AW-1:0] a;

        bus.avs_read = 1'b0;
        bus.avs_write = 1'b0;
        bus.avs_address = '0;
        bus.avs_burstcount = '0;
        bus.avs_writedata = '0;
        bus.avs_byteenable = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_waitreq", 64'(bus.avs_waitrequest), 64'd1);
        check("rst_rdvalid", 64'(bus.avs_readdatavalid), 64'd0);
        check("rst_rdata", bus.avs_readdata, 64'd0);
        check("rst_err", 64'(err_sticky), 64'd0);
        check("rst_rd_beats", 64'(rd_beats), 64'd0);
        check("rst_wr_beats", 64'(wr_beats), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("release_waitreq", 64'(bus.avs_waitrequest), 64'd1);
        @(posedge clk);
        #1;

        // Burst 4 write then read back at 0x10.
        for (int i = 0; i < 4; i++) begin
            wdat[i] = 64'h0123_4567_89AB_CD00 | 64'(i);
            wbe[i]  = 8'hFF;
            exp_beats[i] = 64'h0123_4567_89AB_CD00 | 64'(i);
        end
        do_write(27'h10, 4);
        issue_read(27'h10, 4, acc);
        collect(4, acc, "burst4");
        @(posedge clk);
        #1;
        check("burst4_rd_beats", 64'(rd_beats), 64'd4);
        check("burst4_wr_beats", 64'(wr_beats), 64'd4);

        // Fill the whole array with a known pattern.
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 64; i++) begin
                wdat[i] = fillval(blk * 64 + i);
                wbe[i]  = 8'hFF;
            end
            do_write(AW'(blk * 64), 64);
        end

        // Partial byte-enable merge over all-ones.
        wdat[0] = '1;
        wbe[0]  = 8'hFF;
        do_write(27'h20, 1);
        wdat[0] = 64'h0123_4567_89AB_CDEF;
        wbe[0]  = 8'h0F;
        do_write(27'h20, 1);
        wbe[0]  = 8'hFF;
        issue_read(27'h20, 1, acc);
        exp_beats[0] = 64'hFFFF_FFFF_89AB_CDEF;
        collect(1, acc, "be_merge");

        // Read at issue: a write right after the read burst must not leak into it.
        wdat[0] = 64'h0000_0000_0000_01D0;
        do_write(27'h40, 1);
        issue_read(27'h40, 2, acc);
        exp_beats[0] = 64'h0000_0000_0000_01D0;
        exp_beats[1] = fillval(32'h41);
        wdat[0] = 64'h0000_0000_0000_0E80;
        do_write(27'h40, 1);
        collect(2, acc, "rd_old");
        issue_read(27'h40, 1, acc);
        exp_beats[0] = 64'h0000_0000_0000_0E80;
        collect(1, acc, "rd_new");

        // read & write together in IDLE.
        check("err_before", 64'(err_sticky), 64'd0);
        bus.avs_read = 1'b1;
        bus.avs_write = 1'b1;
        bus.avs_address = 27'h41;
        bus.avs_burstcount = 7'd1;
        bus.avs_writedata = 64'hDEAD_BEEF_DEAD_BEEF;
        bus.avs_byteenable = 8'hFF;
        wait_accept(1'b0, acc);
        bus.avs_read = 1'b0;
        bus.avs_write = 1'b0;
        @(posedge clk);
        #1;
        check("rw_err", 64'(err_sticky), 64'd1);
        check("rw_wr_beats", 64'(wr_beats), 64'(exp_wr));
        issue_read(27'h41, 1, acc);
        exp_beats[0] = fillval(32'h41);
        collect(1, acc, "rw_nochange");
        @(posedge clk);
        #1;
        check("rw_rd_beats", 64'(rd_beats), 64'(exp_rd));

        // Reset clears the sticky error; then burstcount 0.
        reset_n = 1'b0;
        #1;
        check("rst2_err", 64'(err_sticky), 64'd0);
        check("rst2_rd_beats", 64'(rd_beats), 64'd0);
        exp_rd = 0;
        exp_wr = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        bus.avs_write = 1'b1;
        bus.avs_address = 27'h42;
        bus.avs_burstcount = 7'd0;
        bus.avs_writedata = 64'hDEAD_BEEF_DEAD_BEEF;
        wait_accept(1'b0, acc);
        bus.avs_write = 1'b0;
        @(posedge clk);
        #1;
        check("bc0_err", 64'(err_sticky), 64'd1);
        check("bc0_wr_beats", 64'(wr_beats), 64'd0);
        issue_read(27'h42, 1, acc);
        exp_beats[0] = fillval(32'h42);
        collect(1, acc, "bc0_nochange");

        // Address wrap at the top of the array; upper address bits ignored.
        for (int i = 0; i < 3; i++) wdat[i] = 64'hAAAA_0000_0000_0000 | 64'(i);
        do_write(27'h5AB_CDFF, 3);
        issue_read(27'h0FF, 3, acc);
        for (int i = 0; i < 3; i++) exp_beats[i] = 64'hAAAA_0000_0000_0000 | 64'(i);
        collect(3, acc, "wrap");
        issue_read(27'h100, 2, acc);
        exp_beats[0] = 64'hAAAA_0000_0000_0001;
        exp_beats[1] = 64'hAAAA_0000_0000_0002;
        collect(2, acc, "wrap_idx0");

        // Reset in the middle of a read burst of 8, after beat 3 has issued.
        issue_read(27'h0, 8, acc);
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_rdvalid", 64'(bus.avs_readdatavalid), 64'd0);
        check("midrst_waitreq", 64'(bus.avs_waitrequest), 64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_stray", 64'(rq_data.size()), 64'd0);
        check("midrst_rd_beats", 64'(rd_beats), 64'd0);
        rq_data.delete();
        rq_cyc.delete();
        exp_rd = 0;
        exp_wr = 0;

        // Random bursts against the reference array.
        for (int t = 0; t < 1000; t++) begin
            a = AW'($urandom);
            n = int'($urandom_range(1, 8));
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < n; i++) begin
                    wdat[i] = {$urandom, $urandom};
                    wbe[i]  = 8'($urandom);
                end
                do_write(a, n);
            end else begin
                for (int i = 0; i < n; i++) exp_beats[i] = model[a[ML-1:0] + ML'(i)];
                issue_read(a, n, acc);
                collect(n, acc, "rand");
            end
        end
        @(posedge clk);
        #1;
        check("rand_rd_beats", 64'(rd_beats), 64'(exp_rd));
        check("rand_wr_beats", 64'(wr_beats), 64'(exp_wr));
        check("stall_seen", 64'(n_stall != 0), 64'd1);
        check("final_err", 64'(err_sticky), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
